// File: rtl/rx_sekwencer_pkg.sv
// Shared definitions for the register-file operand sequencer: FSM state
// encoding and default geometry/timeout values.
package rx_pkg;

    // Sequencer phases: idle, read operand A, read operand B, wait for the
    // ALU, write the result back.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ODCZYT_A   = 3'd1,
        ODCZYT_B   = 3'd2,
        CZEKAJ_ALU = 3'd3,
        ZAPIS      = 3'd4
    } rx_stan_t;

    localparam int RX_LICZBA    = 8;   // number of registers
    localparam int RX_ROZM_DATA = 8;   // data width
    localparam int TIMEOUT      = 15;  // max cycles waiting for the ALU

endpackage

// File: rtl/rx_sekwencer_licznik_timeout.sv
// Cycle counter that bounds how long the sequencer waits for the ALU.
// terminal goes high once the count has reached TIMEOUT and stays there
// until the counter is cleared.
module rx_licznik_timeout #(
    parameter  int TIMEOUT = rx_pkg::TIMEOUT,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Reached the limit; the count saturates here so it can never wrap.
    assign terminal = (cnt_q == CW'(TIMEOUT));

    // Next count: clear has priority over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !terminal) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_sekwencer.sv
// Operand-fetch / write-back sequencer for a single-port register file.
// Reads rd then rs through the shared index, hands both operands to the
// ALU, waits (bounded) for the result and writes it back to rd.
module rx_sekwencer #(
    parameter  int RX_LICZBA    = rx_pkg::RX_LICZBA,
    parameter  int RX_ROZM_DATA = rx_pkg::RX_ROZM_DATA,
    parameter  int TIMEOUT      = rx_pkg::TIMEOUT,
    localparam int IW           = $clog2(RX_LICZBA),
    localparam int DW           = RX_ROZM_DATA
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [IW-1:0] rd_idx,
    input  logic [IW-1:0] rs_idx,
    input  logic          wb_en,
    output logic          busy,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic          op_valid,
    input  logic [DW-1:0] alu_wynik,
    input  logic          alu_valid,
    output logic          done,
    output logic          blad,
    output logic          rf_wr,
    output logic [IW-1:0] rf_nr,
    output logic [DW-1:0] rf_dane,
    input  logic [DW-1:0] rf_out
);

    import rx_pkg::*;

    rx_stan_t      state_q, state_d;
    logic [IW-1:0] rd_q, rd_d;
    logic [IW-1:0] rs_q, rs_d;
    logic          wb_q, wb_d;
    logic [DW-1:0] op_a_q, op_a_d;
    logic [DW-1:0] op_b_q, op_b_d;
    logic [DW-1:0] wynik_q, wynik_d;
    logic          blad_q, blad_d;

    logic cnt_clear;
    logic cnt_enable;
    logic cnt_terminal;

    rx_licznik_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_licznik (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .terminal (cnt_terminal)
    );

    assign op_a = op_a_q;
    assign op_b = op_b_q;
    assign blad = blad_q;

    // Next state, register updates and state-decoded port outputs.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        rs_d       = rs_q;
        wb_d       = wb_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        wynik_d    = wynik_q;
        blad_d     = blad_q;
        busy       = 1'b1;
        op_valid   = 1'b0;
        done       = 1'b0;
        rf_wr      = 1'b0;
        rf_nr      = '0;
        rf_dane    = '0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    rd_d    = rd_idx;
                    rs_d    = rs_idx;
                    wb_d    = wb_en;
                    blad_d  = 1'b0;
                    state_d = ODCZYT_A;
                end
            end
            ODCZYT_A: begin
                rf_nr   = rd_q;
                op_a_d  = rf_out;
                state_d = ODCZYT_B;
            end
            ODCZYT_B: begin
                rf_nr     = rs_q;
                op_b_d    = rf_out;
                cnt_clear = 1'b1;
                state_d   = CZEKAJ_ALU;
            end
            CZEKAJ_ALU: begin
                rf_nr    = rd_q;
                op_valid = 1'b1;
                // A result arriving on the terminal cycle still wins.
                if (alu_valid) begin
                    wynik_d = alu_wynik;
                    state_d = ZAPIS;
                end else if (cnt_terminal) begin
                    blad_d  = 1'b1;
                    state_d = ZAPIS;
                end else begin
                    cnt_enable = 1'b1;
                end
            end
            ZAPIS: begin
                rf_nr   = rd_q;
                rf_dane = wynik_q;
                done    = 1'b1;
                // Reset in this cycle must not let the write land.
                rf_wr   = wb_q & ~blad_q & ~rst;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q    <= '0;
            rs_q    <= '0;
            wb_q    <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            wynik_q <= '0;
            blad_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            rs_q    <= rs_d;
            wb_q    <= wb_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            wynik_q <= wynik_d;
            blad_q  <= blad_d;
        end
    end

endmodule

// File: tb/tb_rx_sekwencer.sv
// Bench for rx_sekwencer: a bench-side register file, a driver that issues
// operations and pushes expectations, and a monitor that checks them.
module tb_rx_sekwencer;

    localparam int IW = 3;
    localparam int DW = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [IW-1:0] rd_idx, rs_idx;
    logic          wb_en;
    logic          busy;
    logic [DW-1:0] op_a, op_b;
    logic          op_valid;
    logic [DW-1:0] alu_wynik;
    logic          alu_valid;
    logic          done;
    logic          blad;
    logic          rf_wr;
    logic [IW-1:0] rf_nr;
    logic [DW-1:0] rf_dane;
    logic [DW-1:0] rf_out;

    // Bench-side preload port into the register file.
    logic          tb_wr;
    logic [IW-1:0] tb_nr;
    logic [DW-1:0] tb_dane;

    rx_sekwencer #(
        .RX_LICZBA    (8),
        .RX_ROZM_DATA (8),
        .TIMEOUT      (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rd_idx    (rd_idx),
        .rs_idx    (rs_idx),
        .wb_en     (wb_en),
        .busy      (busy),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_valid  (op_valid),
        .alu_wynik (alu_wynik),
        .alu_valid (alu_valid),
        .done      (done),
        .blad      (blad),
        .rf_wr     (rf_wr),
        .rf_nr     (rf_nr),
        .rf_dane   (rf_dane),
        .rf_out    (rf_out)
    );

    always #5 clk = ~clk;

    // Register file: combinational read, write on the rising edge.
    logic [DW-1:0] rf_mem [8];
    assign rf_out = rf_mem[rf_nr];
    always @(posedge clk) begin
        if (rf_wr) rf_mem[rf_nr] <= rf_dane;
        else if (tb_wr) rf_mem[tb_nr] <= tb_dane;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            cyc;
    } opnd_t;

    typedef struct {
        logic          blad;
        logic          wr;
        logic [IW-1:0] nr;
        logic [DW-1:0] dane;
        int            cyc;
    } res_t;

    opnd_t opq[$];
    res_t  rq[$];

    // Reference model state: register contents and the last accepted result.
    logic [DW-1:0] ref_mem [8];
    logic [DW-1:0] last_res = '0;

    int errors = 0;
    int checks = 0;
    int txn    = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: compare operands when op_valid rises and the write-back on done.
    logic  prev_opv = 1'b0;
    opnd_t m_op;
    res_t  m_res;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (op_valid && !prev_opv) begin
                if (opq.size() == 0) begin
                    chk("unexpected_op_valid", 1, 0);
                end else begin
                    m_op = opq.pop_front();
                    chk("op_valid_cycle", cyc, m_op.cyc);
                    chk("op_a", op_a, m_op.a);
                    chk("op_b", op_b, m_op.b);
                end
            end
            prev_opv = op_valid;
            if (done) begin
                if (rq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    m_res = rq.pop_front();
                    chk("done_cycle", cyc, m_res.cyc);
                    chk("blad", blad, m_res.blad);
                    chk("rf_wr", rf_wr, m_res.wr);
                    chk("rf_nr", rf_nr, m_res.nr);
                    chk("rf_dane", rf_dane, m_res.dane);
                    $display("txn %0d: cycle=%0d nr=%0d wr=%0b dane=0x%02h blad=%0b",
                             txn, cyc, rf_nr, rf_wr, rf_dane, blad);
                    txn++;
                end
            end else begin
                chk("wr_outside_zapis", rf_wr, 0);
            end
        end
    end

    task automatic preload(input int i, input logic [DW-1:0] v);
        tb_wr   = 1'b1;
        tb_nr   = IW'(i);
        tb_dane = v;
        ref_mem[i] = v;
        @(negedge clk);
        tb_wr = 1'b0;
    endtask

    // Issue one operation. d = cycles after op_valid rises before alu_valid;
    // d > TO means the ALU never answers. noise injects ignored start and
    // alu_valid pulses; rz asserts reset during the write-back cycle.
    task automatic run_op(input logic [IW-1:0] rd, input logic [IW-1:0] rs,
                          input logic wb, input logic [DW-1:0] res, input int d,
                          input bit noise, input bit rz, output int t_issue);
        int    lim;
        int    t;
        int    donec;
        bit    to;
        opnd_t eo;
        res_t  er;
        lim = 0;
        while (busy && lim < 100) begin
            @(negedge clk);
            lim++;
        end
        if (busy) begin
            chk("idle_wait_timeout", busy, 0);
            t_issue = cyc;
            return;
        end
        if (noise) begin
            alu_valid = 1'b1;
            alu_wynik = DW'($urandom);
            @(negedge clk);
            alu_valid = 1'b0;
            chk("idle_alu_ignored", busy, 0);
        end
        t       = cyc;
        t_issue = t;
        to      = (d > TO);
        donec   = t + 4 + (to ? TO : d);
        eo.a    = ref_mem[rd];
        eo.b    = ref_mem[rs];
        eo.cyc  = t + 3;
        opq.push_back(eo);
        if (!to) last_res = res;
        er.blad = to;
        er.wr   = wb && !to && !rz;
        er.nr   = rd;
        er.dane = last_res;
        er.cyc  = donec;
        rq.push_back(er);
        if (er.wr) ref_mem[rd] = res;
        if (rz) last_res = '0;

        rd_idx = rd;
        rs_idx = rs;
        wb_en  = wb;
        start  = 1'b1;
        while (cyc < donec) begin
            @(negedge clk);
            start     = noise && (cyc == t + 2 || cyc == t + 4);
            if (noise) begin
                rd_idx = IW'($urandom);
                rs_idx = IW'($urandom);
                wb_en  = 1'($urandom);
            end
            alu_valid = !to && (cyc == t + 3 + d);
            alu_wynik = alu_valid ? res : DW'($urandom);
            rst       = rz && (cyc == donec);
        end
        @(negedge clk);
        start     = 1'b0;
        alu_valid = 1'b0;
        rst       = 1'b0;
        chk("busy_after_op", busy, 0);
        if (rz) begin
            chk("rst_op_a", op_a, 0);
            chk("rst_op_b", op_b, 0);
            chk("rst_blad", blad, 0);
        end else begin
            chk("blad_held", blad, to);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    int t0, t1, dummy;
    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        rd_idx    = '0;
        rs_idx    = '0;
        wb_en     = 1'b0;
        alu_wynik = '0;
        alu_valid = 1'b0;
        tb_wr     = 1'b0;
        tb_nr     = '0;
        tb_dane   = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_op_valid", op_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_blad", blad, 0);
        chk("reset_op_a", op_a, 0);
        chk("reset_op_b", op_b, 0);
        chk("reset_rf_wr", rf_wr, 0);
        chk("reset_rf_nr", rf_nr, 0);
        chk("reset_rf_dane", rf_dane, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            preload(i, (i == 2) ? 8'h11 : (i == 5) ? 8'h22 : (i == 4) ? 8'h7F : DW'($urandom));
        end

        // Basic write-back.
        run_op(3'd2, 3'd5, 1'b1, 8'h33, 0, 1'b0, 1'b0, dummy);
        chk("r2_written", rf_mem[2], 8'h33);

        // Write-back disabled.
        preload(2, 8'h11);
        run_op(3'd2, 3'd5, 1'b0, 8'h33, 2, 1'b0, 1'b0, dummy);
        chk("r2_unchanged", rf_mem[2], 8'h11);

        // Same register for both operands.
        run_op(3'd4, 3'd4, 1'b1, 8'hFE, 1, 1'b0, 1'b0, dummy);
        chk("r4_written", rf_mem[4], 8'hFE);

        // Timeout, then an immediate follow-up start.
        run_op(3'd1, 3'd3, 1'b1, 8'h55, 99, 1'b0, 1'b0, t0);
        run_op(3'd3, 3'd1, 1'b1, 8'h66, 0, 1'b0, 1'b0, t1);
        chk("restart_after_timeout", t1, t0 + 20);

        // Result on the terminal-count cycle wins.
        run_op(3'd6, 3'd0, 1'b1, 8'hA5, TO, 1'b0, 1'b0, dummy);

        // Ignored start / alu_valid pulses.
        run_op(3'd7, 3'd2, 1'b1, 8'h3C, 4, 1'b1, 1'b0, dummy);

        // Reset in the write-back cycle.
        run_op(3'd5, 3'd6, 1'b1, 8'hC3, 3, 1'b0, 1'b1, dummy);

        for (int n = 0; n < 40; n++) begin
            run_op(IW'($urandom), IW'($urandom), 1'($urandom), DW'($urandom),
                   $urandom_range(0, TO + 3), 1'($urandom), ($urandom_range(0, 9) == 0),
                   dummy);
        end

        repeat (3) @(negedge clk);
        chk("opq_drained", opq.size(), 0);
        chk("rq_drained", rq.size(), 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rf_final_r%0d", i), rf_mem[i], ref_mem[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rx_sekwencer.md
# rx_sekwencer

Operand-fetch / write-back sequencer for the single-port register file, where one index drives both read and write. The sequencer accepts one register-to-register operation from the instruction decoder and reads operand A (`rd`) and then operand B (`rs`) through the shared port. It presents both operands to the ALU, waits for the result, and writes it back to `rd`. It owns the register file's `wr_Rx` / `nr_Rx` / `dane` inputs and is the only master of that port.

## Interface
- `RX_LICZBA`, 8: number of registers; index width `IW = $clog2(RX_LICZBA)`.
- `RX_ROZM_DATA`, 8: data width `DW`.
- `TIMEOUT`, 15: maximum number of cycles spent waiting for `alu_valid`; counter width `$clog2(TIMEOUT+1)`.

Ports (clock and reset first):
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: operation request from the decoder; sampled only in IDLE.
- `rd_idx` in IW: destination register, also the source of operand A; latched when `start` is accepted.
- `rs_idx` in IW: source register for operand B; latched when `start` is accepted.
- `wb_en` in 1: enables the write-back; latched when `start` is accepted.
- `busy` out 1: high in every state except IDLE.
- `op_a` out DW: registered operand A.
- `op_b` out DW: registered operand B.
- `op_valid` out 1: high for the whole of CZEKAJ_ALU.
- `alu_wynik` in DW: result from the ALU.
- `alu_valid` in 1: result strobe; ignored outside CZEKAJ_ALU.
- `done` out 1: one-cycle pulse in ZAPIS.
- `blad` out 1: registered timeout flag; valid in the ZAPIS cycle.
- `rf_wr` out 1: connects to the register file's `wr_Rx`.
- `rf_nr` out IW: connects to `nr_Rx`.
- `rf_dane` out DW: connects to `dane`.
- `rf_out` in DW: combinational read data from the register file.

## Operation
- FSM states: IDLE, ODCZYT_A, ODCZYT_B, CZEKAJ_ALU, ZAPIS.
- IDLE: `rf_nr`=0, `rf_wr`=0. On `start`, latch `rd_idx`, `rs_idx`, `wb_en`, clear `blad`, go to ODCZYT_A.
- ODCZYT_A: `rf_nr`=rd; `op_a` <= `rf_out`; go to ODCZYT_B.
- ODCZYT_B: `rf_nr`=rs; `op_b` <= `rf_out`; clear the timeout counter; go to CZEKAJ_ALU.
- CZEKAJ_ALU: `rf_nr`=rd, `op_valid`=1.
  - On `alu_valid`: latch `alu_wynik`, go to ZAPIS.
  - Otherwise increment the counter. When the counter reaches TIMEOUT without `alu_valid`: set `blad`=1, go to ZAPIS.
- ZAPIS: `rf_nr`=rd, `rf_dane`=latched result, `done`=1; go to IDLE.
  - `rf_wr` = `wb_en_reg & ~blad & ~rst`.
- `rd == rs` is legal; both reads hit the same register.
- `start` while `busy` is ignored; no queueing.
- The sequencer performs no arithmetic; data passes through unchanged at DW bits.

## Timing
- Reset values: state IDLE; `op_a`, `op_b`, the latched result, `blad`, the counter and the latched indices all 0. All outputs are 0.
- `start` high in cycle t (IDLE) gives:
  - `busy` from t+1;
  - `op_a` valid from t+2;
  - `op_b` and `op_valid` from t+3.
- `alu_valid` in cycle u ≥ t+3 gives ZAPIS in cycle u+1 (write takes effect at the end of u+1, `done` high in u+1) and IDLE in u+2. The earliest next accepted `start` is in u+2.
- `alu_valid` arriving in the same cycle the counter reaches TIMEOUT: the result wins and `blad` stays 0.
- Without `alu_valid`: ZAPIS in cycle t+4+TIMEOUT with `blad`=1 and no write.
- `rst` in any state: IDLE on the next edge. If the reset cycle falls in ZAPIS, `rf_wr` is 0 and `done` is still allowed.
- Outputs `busy`, `op_valid`, `done`, `rf_*` are combinational from state; `op_a`, `op_b`, `blad` are registered.

## Structure
- Package `rx_pkg`:
  - `typedef enum logic [2:0]` for the FSM state;
  - default width constants `RX_LICZBA`, `RX_ROZM_DATA`, `TIMEOUT`.
- One sub-module, `rx_licznik_timeout`: ports clear, enable, terminal-count flag; parameter TIMEOUT.
- The top level instantiates nothing else. The bench wires it to the register file.

## Test plan
- After reset, preload R2=0x11 and R5=0x22 through a bench-side write. Send `start`, rd=2, rs=5, wb_en=1.
  - Required: `op_a`=0x11 and `op_b`=0x22 with `op_valid` at t+3.
  - Then `alu_valid` with 0x33: R2 reads 0x33 after `done`, and `done` lasts exactly one cycle.
- Same operation with wb_en=0 and `alu_valid` with 0x33: `done` pulses, `rf_wr` never high, R2 still 0x11.
- rd=rs=4 with R4=0x7F: `op_a`=`op_b`=0x7F; result 0xFE is written to R4.
- No `alu_valid`, TIMEOUT=15:
  - Required: ZAPIS at t+19 with `blad`=1, no write.
  - Then a second `start` at t+20 is accepted.
- Corner cases:
  - `start` pulses during ODCZYT_B and CZEKAJ_ALU are ignored.
  - `alu_valid` pulses in IDLE are ignored.
  - `rst` asserted in the ZAPIS cycle gives `rf_wr`=0 and `busy`=0 on the next edge.
